// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency 32 cycles accept-to-done (1 for div-by-zero/overflow); start is ignored while busy.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RD_W-1:0] rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              fast_q, fast_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, fast_val;

    always_comb begin
        a_signed = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
        b_signed = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        a_neg    = a_signed & rs1_data[XLEN-1];
        b_neg    = b_signed & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = funct3[2] && (rs2_data == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1_data == SMIN) && (rs2_data == '1);
        // funct3[1] selects remainder flavour for the divide fast path
        fast_val = funct3[1] ? (div_zero ? rs1_data : '0) : (div_zero ? '1 : SMIN);
    end

    // work_q holds {hi, lo}: partial product/multiplier, or remainder/dividend-quotient
    logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quo, rem, fin;

    always_comb begin
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (rem_diff[XLEN])
                step = {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
            else
                step = {rem_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        end else begin
            step = {mul_sum, work_q[XLEN-1:1]};
        end
        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op_q[2])
            fin = op_q[1] ? rem : quo;
        else
            fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        fast_d   = fast_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    count_d = '0;
                    op_d    = funct3;
                    rd_d    = rd_in;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    fast_d  = div_zero | div_ovf;
                    if (div_zero | div_ovf) begin
                        work_d = {{XLEN{1'b0}}, fast_val};
                        opnd_d = '0;
                    end else if (funct3[2]) begin
                        work_d = {{XLEN{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        work_d = {{XLEN{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            S_CALC: begin
                // fast-path results spend a single cycle here with no iteration
                if (fast_q) begin
                    result_d = work_q[XLEN-1:0];
                    state_d  = S_DONE;
                end else begin
                    work_d  = step;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(XLEN-1)) begin
                        result_d = fin;
                        state_d  = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            fast_q   <= 1'b0;
            work_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            rd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            fast_q   <= fast_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_q;
endmodule
